// File: rtl/lc_ram_pkg.sv
// Shared constants for the language-card RAM arbiter: FSM state codes,
// requester IDs and RAM port widths.
package lc_ram_pkg;

  localparam int RAM_AW = 18;
  localparam int RAM_DW = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] REQ_VID = 2'd0;
  localparam logic [1:0] REQ_CPU = 2'd1;
  localparam logic [1:0] REQ_DL  = 2'd2;

  // The loader only ever writes; the video scanner only ever reads.
  function automatic logic req_is_write(input logic [1:0] id, input logic cpu_we);
    return (id == REQ_DL) || ((id == REQ_CPU) && cpu_we);
  endfunction

endpackage

// File: rtl/lc_ram_prio_sel.sv
// Combinational winner select for the RAM arbiter: fixed VID > CPU > DL
// priority, with an override that lets an aged loader request jump the queue.
module lc_ram_prio_sel
  import lc_ram_pkg::*;
(
  input  logic       idle_i,
  input  logic       vid_req_i,
  input  logic       cpu_req_i,
  input  logic       dl_req_i,
  input  logic       dl_force_i,
  output logic       grant_o,
  output logic [1:0] grant_id_o
);

  always_comb begin
    grant_o    = 1'b0;
    grant_id_o = REQ_VID;
    if (idle_i) begin
      if (dl_force_i && dl_req_i) begin
        grant_o    = 1'b1;
        grant_id_o = REQ_DL;
      end else if (vid_req_i) begin
        grant_o    = 1'b1;
        grant_id_o = REQ_VID;
      end else if (cpu_req_i) begin
        grant_o    = 1'b1;
        grant_id_o = REQ_CPU;
      end else if (dl_req_i) begin
        grant_o    = 1'b1;
        grant_id_o = REQ_DL;
      end
    end
  end

endmodule

// File: rtl/lc_ram_arbiter.sv
// Single-port main/language-card RAM arbiter for VID, CPU and loader.
// Optional loader aging is enabled by defining LC_RAM_ARB_DL_AGING_EN.
//
// Handshake: each req is a level sampled only in IDLE; the winner's
// addr/data/direction are latched there, the RAM cycle lasts RAM_LAT clocks,
// and the winner's ack pulses for exactly one clock (DONE) with its dout
// valid in that same clock. A req still high in the following IDLE is a new
// request.
module lc_ram_arbiter
  import lc_ram_pkg::*;
#(
  parameter int unsigned RAM_LAT     = 3,
  parameter int unsigned DL_MAX_WAIT = 15
) (
  input  logic              mclk28,
  input  logic              reset_in,
  input  logic              vid_req,
  input  logic [RAM_AW-1:0] vid_addr,
  output logic              vid_ack,
  output logic [RAM_DW-1:0] vid_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [RAM_DW-1:0] cpu_din,
  output logic              cpu_ack,
  output logic [RAM_DW-1:0] cpu_dout,
  input  logic              dl_req,
  input  logic [RAM_AW-1:0] dl_addr,
  input  logic [RAM_DW-1:0] dl_din,
  output logic              dl_ack,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_din,
  input  logic [RAM_DW-1:0] ram_dout,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [1:0]        dbg_state
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        win_q;
  logic              wr_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [RAM_DW-1:0] ram_din_q;
  logic [RAM_DW-1:0] vid_dout_q, cpu_dout_q;

  logic              grant;
  logic [1:0]        grant_id;
  logic              dl_force;
  logic              last_access;

  lc_ram_prio_sel u_prio_sel (
    .idle_i     (state_q == ST_IDLE),
    .vid_req_i  (vid_req),
    .cpu_req_i  (cpu_req),
    .dl_req_i   (dl_req),
    .dl_force_i (dl_force),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

`ifdef LC_RAM_ARB_DL_AGING_EN
  logic [7:0] dl_wait_q, dl_wait_d;

  // Counts arbitrations the loader lost while asking; saturates at 255.
  always_comb begin
    dl_wait_d = dl_wait_q;
    if (grant) begin
      if (grant_id == REQ_DL) begin
        dl_wait_d = 8'd0;
      end else if (dl_req && (dl_wait_q != 8'hFF)) begin
        dl_wait_d = dl_wait_q + 8'd1;
      end
    end
  end

  always_ff @(posedge mclk28) begin
    if (reset_in) begin
      dl_wait_q <= 8'd0;
    end else begin
      dl_wait_q <= dl_wait_d;
    end
  end

  assign dl_force = (dl_wait_q >= 8'(DL_MAX_WAIT));
`else
  assign dl_force = 1'b0;
`endif

  assign last_access = (state_q == ST_ACCESS) && (cnt_q == 3'd0);

  always_ff @(posedge mclk28) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_ACCESS;
          cnt_d   = 3'(RAM_LAT - 1);
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_we    = (state_q == ST_ACCESS) && wr_q;
    ram_oe    = (state_q == ST_ACCESS) && !wr_q;
    vid_ack   = (state_q == ST_DONE) && (win_q == REQ_VID);
    cpu_ack   = (state_q == ST_DONE) && (win_q == REQ_CPU);
    dl_ack    = (state_q == ST_DONE) && (win_q == REQ_DL);
    dbg_state = state_q;
  end

  // Winner's request is frozen at grant; read data lands as DONE begins.
  always_ff @(posedge mclk28) begin
    if (reset_in) begin
      win_q      <= REQ_VID;
      wr_q       <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      vid_dout_q <= '0;
      cpu_dout_q <= '0;
    end else begin
      if (grant) begin
        win_q <= grant_id;
        wr_q  <= req_is_write(grant_id, cpu_we);
        case (grant_id)
          REQ_VID: begin
            ram_addr_q <= vid_addr;
            ram_din_q  <= '0;
          end
          REQ_CPU: begin
            ram_addr_q <= cpu_addr;
            ram_din_q  <= cpu_din;
          end
          default: begin
            ram_addr_q <= dl_addr;
            ram_din_q  <= dl_din;
          end
        endcase
      end
      if (last_access && !wr_q) begin
        if (win_q == REQ_VID) vid_dout_q <= ram_dout;
        if (win_q == REQ_CPU) cpu_dout_q <= ram_dout;
      end
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign vid_dout = vid_dout_q;
  assign cpu_dout = cpu_dout_q;

endmodule

// File: tb/tb_lc_ram_arbiter.sv
// Self-checking bench for lc_ram_arbiter: directed scenarios followed by
// random concurrent traffic, checked through per-requester expected queues.
module tb_lc_ram_arbiter;
  import lc_ram_pkg::*;

  localparam int RL  = 3;
  localparam int DLW = 4;

  logic        mclk28 = 1'b0;
  logic        reset_in = 1'b0;
  logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, dl_req = 1'b0;
  logic [17:0] vid_addr = '0, cpu_addr = '0, dl_addr = '0;
  logic [7:0]  cpu_din = '0, dl_din = '0;
  logic        vid_ack, cpu_ack, dl_ack, ram_we, ram_oe;
  logic [7:0]  vid_dout, cpu_dout, ram_din, ram_dout;
  logic [17:0] ram_addr;
  logic [1:0]  dbg_state;
  logic        ram_force = 1'b0;
  logic [7:0]  ram_force_val = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cyc = 0;

  lc_ram_arbiter #(.RAM_LAT(RL), .DL_MAX_WAIT(DLW)) dut (
    .mclk28(mclk28), .reset_in(reset_in),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_we(ram_we), .ram_oe(ram_oe), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 mclk28 = ~mclk28;
  always @(posedge mclk28) cyc <= cyc + 1;

  logic rst_at_edge = 1'b0;
  always @(posedge mclk28) rst_at_edge <= reset_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  // RAM content model: each address reads back a fixed function of itself.
  function automatic logic [7:0] ram_fn(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h5A;
  endfunction
  assign ram_dout = ram_force ? ram_force_val : ram_fn(ram_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [26:0] vid_q[$], cpu_q[$], dl_q[$];

  function automatic logic [26:0] mk(input logic we, input logic [17:0] a, input logic [7:0] d);
    return {we, a, d};
  endfunction

  int          acc_len = 0, done_len = 0;
  logic [17:0] acc_addr, done_addr;
  logic [7:0]  acc_din, done_din;
  logic        acc_we, done_we;
  int          last_ack = -1000;
  logic [7:0]  pv_vid = 8'h00, pv_cpu = 8'h00;

  task automatic sb_cmp(input string nm, input logic [26:0] e, input logic [7:0] dout);
    chk({nm, "_len"}, done_len, RL);
    chk({nm, "_dir"}, done_we, e[26]);
    chk({nm, "_addr"}, done_addr, e[25:8]);
    if (e[26]) chk({nm, "_wdata"}, done_din, e[7:0]);
    else       chk({nm, "_rdata"}, dout, e[7:0]);
  endtask

  always @(negedge mclk28) begin
    if (ram_we || ram_oe) begin
      chk("we_oe_excl", ram_we & ram_oe, 0);
      if (acc_len == 0) begin
        acc_addr = ram_addr; acc_din = ram_din; acc_we = ram_we;
      end else begin
        chk("hold_addr", ram_addr, acc_addr);
        chk("hold_din", ram_din, acc_din);
        chk("hold_dir", ram_we, acc_we);
      end
      acc_len++;
    end else if (acc_len != 0) begin
      done_addr = acc_addr; done_din = acc_din; done_we = acc_we;
      done_len = acc_len; acc_len = 0;
    end
    if (vid_ack || cpu_ack || dl_ack) begin
      chk("ack_onehot", int'(vid_ack) + int'(cpu_ack) + int'(dl_ack), 1);
      chk("ack_spacing", (int'(cyc) - last_ack) >= RL + 2, 1);
      last_ack = int'(cyc);
      if (vid_ack) begin
        if (vid_q.size() == 0) chk("vid_unexpected_ack", 1, 0);
        else sb_cmp("vid", vid_q.pop_front(), vid_dout);
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0) chk("cpu_unexpected_ack", 1, 0);
        else sb_cmp("cpu", cpu_q.pop_front(), cpu_dout);
      end
      if (dl_ack) begin
        if (dl_q.size() == 0) chk("dl_unexpected_ack", 1, 0);
        else sb_cmp("dl", dl_q.pop_front(), 8'h00);
      end
    end
    if (!rst_at_edge && vid_dout !== pv_vid) chk("vid_dout_only_in_done", vid_ack, 1);
    if (!rst_at_edge && cpu_dout !== pv_cpu) chk("cpu_dout_only_in_done", cpu_ack, 1);
    pv_vid = vid_dout;
    pv_cpu = cpu_dout;
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge mclk28);
  endtask

  task automatic vid_txn(input logic [17:0] a);
    int t = 0;
    vid_addr = a; vid_req = 1'b1;
    vid_q.push_back(mk(1'b0, a, ram_fn(a)));
    do begin tick(); t++; end while (!vid_ack && t < 1000);
    if (!vid_ack) chk("vid_timeout", 0, 1);
    vid_req = 1'b0;
  endtask

  task automatic cpu_txn(input logic we, input logic [17:0] a, input logic [7:0] d);
    int t = 0;
    cpu_we = we; cpu_addr = a; cpu_din = d; cpu_req = 1'b1;
    cpu_q.push_back(mk(we, a, we ? d : ram_fn(a)));
    do begin tick(); t++; end while (!cpu_ack && t < 1000);
    if (!cpu_ack) chk("cpu_timeout", 0, 1);
    cpu_req = 1'b0;
  endtask

  task automatic dl_txn(input logic [17:0] a, input logic [7:0] d);
    int t = 0;
    dl_addr = a; dl_din = d; dl_req = 1'b1;
    dl_q.push_back(mk(1'b1, a, d));
    do begin tick(); t++; end while (!dl_ack && t < 1000);
    if (!dl_ack) chk("dl_timeout", 0, 1);
    dl_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_v, t_c, t_d, vid_cnt, dl_at, nack, acks[3];
    bit we_seen;

    reset_in = 1'b1;
    repeat (3) tick();
    reset_in = 1'b0;
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_we_oe", {ram_we, ram_oe}, 0);
    chk("rst_acks", {vid_ack, cpu_ack, dl_ack}, 0);
    chk("rst_douts", {vid_dout, cpu_dout}, 0);
    tick();

    // Single CPU read with forced RAM data.
    ram_force = 1'b1; ram_force_val = 8'hA5;
    cpu_we = 1'b0; cpu_addr = 18'h0D123; cpu_req = 1'b1;
    cpu_q.push_back(mk(1'b0, 18'h0D123, 8'hA5));
    we_seen = 1'b0;
    for (int k = 1; k <= RL + 2; k++) begin
      tick();
      we_seen |= ram_we;
      if (k <= RL) begin
        chk("t1_oe", ram_oe, 1);
        chk("t1_addr", ram_addr, 18'h0D123);
      end
      chk("t1_ack_time", cpu_ack, k == RL + 1);
      if (cpu_ack) begin
        chk("t1_dout", cpu_dout, 8'hA5);
        cpu_req = 1'b0;
      end
    end
    chk("t1_no_we", we_seen, 0);
    ram_force = 1'b0;

    // Simultaneous VID, CPU write, DL write.
    vid_addr = 18'h01234; vid_req = 1'b1;
    vid_q.push_back(mk(1'b0, 18'h01234, ram_fn(18'h01234)));
    cpu_we = 1'b1; cpu_addr = 18'h0E000; cpu_din = 8'h3C; cpu_req = 1'b1;
    cpu_q.push_back(mk(1'b1, 18'h0E000, 8'h3C));
    dl_addr = 18'h3FFFF; dl_din = 8'h77; dl_req = 1'b1;
    dl_q.push_back(mk(1'b1, 18'h3FFFF, 8'h77));
    t_v = -1; t_c = -1; t_d = -1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == RL + 3) begin
        chk("t2_cpu_we", ram_we, 1);
        chk("t2_cpu_din", ram_din, 8'h3C);
        chk("t2_cpu_addr", ram_addr, 18'h0E000);
      end
      if (vid_ack) begin t_v = t; vid_req = 1'b0; end
      if (cpu_ack) begin t_c = t; cpu_req = 1'b0; end
      if (dl_ack)  begin t_d = t; dl_req  = 1'b0; end
    end
    chk("t2_vid_ack_at", t_v, RL + 1);
    chk("t2_cpu_ack_at", t_c, 2 * RL + 3);
    chk("t2_dl_ack_at", t_d, 3 * RL + 5);

    // Address change during ACCESS is ignored.
    cpu_we = 1'b0; cpu_addr = 18'h0D000; cpu_req = 1'b1;
    cpu_q.push_back(mk(1'b0, 18'h0D000, ram_fn(18'h0D000)));
    for (int k = 1; k <= RL + 1; k++) begin
      tick();
      if (k == 1) cpu_addr = 18'h0C000;
      if (k <= RL) chk("t3_addr_held", ram_addr, 18'h0D000);
      if (cpu_ack) cpu_req = 1'b0;
    end
    chk("t3_cpu_req_released", cpu_req, 0);
    tick();

    // Reset during the second ACCESS cycle of a DL write.
    dl_addr = 18'h1ABCD; dl_din = 8'h99; dl_req = 1'b1;
    tick();
    chk("t4_we_a1", ram_we, 1);
    tick();
    chk("t4_we_a2", ram_we, 1);
    reset_in = 1'b1; dl_req = 1'b0;
    tick();
    reset_in = 1'b0;
    chk("t4_we_after_rst", ram_we, 0);
    chk("t4_state_after_rst", dbg_state, ST_IDLE);
    nack = 0;
    repeat (10) begin tick(); nack += int'(dl_ack); end
    chk("t4_no_dl_ack", nack, 0);
    dl_txn(18'h1ABCD, 8'h99);
    tick();

    // VID held continuously against a waiting loader.
    vid_addr = 18'h00777; vid_req = 1'b1;
    vid_q.push_back(mk(1'b0, 18'h00777, ram_fn(18'h00777)));
    dl_addr = 18'h20001; dl_din = 8'hC3; dl_req = 1'b1;
    dl_q.push_back(mk(1'b1, 18'h20001, 8'hC3));
    vid_cnt = 0; dl_at = -1;
    for (int t = 0; t < 800 && (vid_req || dl_req); t++) begin
      tick();
      if (dl_ack) begin dl_at = vid_cnt; dl_req = 1'b0; end
      if (vid_ack) begin
        vid_cnt++;
        if (vid_cnt >= 100 || dl_at >= 0) vid_req = 1'b0;
        else vid_q.push_back(mk(1'b0, 18'h00777, ram_fn(18'h00777)));
      end
    end
`ifdef LC_RAM_ARB_DL_AGING_EN
    chk("t5_dl_after_vid_grants", dl_at, DLW);
`else
    chk("t5_dl_starved_100", dl_at, 100);
`endif
    vid_req = 1'b0; dl_req = 1'b0;
    tick();

    // CPU req held across its ack: back-to-back accesses.
    cpu_we = 1'b0; cpu_addr = 18'h00042; cpu_req = 1'b1;
    repeat (3) cpu_q.push_back(mk(1'b0, 18'h00042, ram_fn(18'h00042)));
    nack = 0;
    for (int t = 1; t <= 40 && nack < 3; t++) begin
      tick();
      if (cpu_ack) begin
        acks[nack] = t; nack++;
        if (nack == 3) cpu_req = 1'b0;
      end
    end
    chk("t6_ack_count", nack, 3);
    chk("t6_first_ack", acks[0], RL + 1);
    chk("t6_ack_gap1", acks[1] - acks[0], RL + 2);
    chk("t6_ack_gap2", acks[2] - acks[1], RL + 2);
    tick();

    // Random concurrent traffic from all three requesters.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(1, 5)) tick();
          vid_txn(18'($urandom_range(0, 18'h3FFFF)));
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(1, 5)) tick();
          cpu_txn(1'($urandom_range(0, 1)), 18'($urandom_range(0, 18'h3FFFF)),
                  8'($urandom_range(0, 255)));
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(1, 5)) tick();
          dl_txn(18'($urandom_range(0, 18'h3FFFF)), 8'($urandom_range(0, 255)));
        end
      end
    join

    repeat (10) tick();
    chk("drain_vid_q", vid_q.size(), 0);
    chk("drain_cpu_q", cpu_q.size(), 0);
    chk("drain_dl_q", dl_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
